uart_frame_checker: RTL and testbench
=====================================

// Module: uart_frame_checker
// PURPOSE
//  Validates the UART byte stream from the byte-level receiver before it reaches uart_reg_mapper.
//  Frame = HDR0, HDR1, PAYLOAD_LEN payload bytes, CHK (sum of payload bytes mod 256).
//  Only good frames update payload_bus and pulse frame_done (drives the mapper's pack_done).
//  Corrupt or stalled frames are dropped with an error pulse.
// PARAMETERS
//  PAYLOAD_LEN  12        payload bytes per frame (1..255); payload_bus byte0 = func_reg
//  HDR0         8'h55     first header byte
//  HDR1         8'hAA     second header byte
//  TIMEOUT_CYC  50000     idle sys_clk cycles allowed between bytes inside a frame (1 ms @ 50 MHz)
// PORTS
//  sys_clk      in   1               50 MHz clock (clk_50M domain)
//  sys_rst_n    in   1               asynchronous, active-HIGH reset (asserted = 1)
//  uart_data    in   8               received byte, valid when uart_done = 1
//  uart_done    in   1               one-cycle strobe per received byte
//  payload_bus  out  PAYLOAD_LEN*8   last good payload; byte k at [8k+7:8k]
//  frame_done   out  1               one-cycle pulse: good frame, payload_bus just updated
//  frame_err    out  1               one-cycle pulse: frame dropped
//  err_code     out  2               00 none, 01 checksum mismatch, 10 inter-byte timeout
//  frame_cnt    out  8               good-frame counter, wraps 255 -> 0
//  busy         out  1               1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; payload_bus, shadow buffer, sum, index and timer = 0.
//   Also frame_done, frame_err, err_code and frame_cnt = 0; busy = 0.
//  FSM states: IDLE, WAIT_HDR1, PAYLOAD, CHECK. Transitions fire only on a cycle with uart_done = 1.
//   IDLE: byte == HDR0 -> WAIT_HDR1; any other byte is ignored.
//   WAIT_HDR1:
//    - byte == HDR1 -> PAYLOAD; index = 0, sum = 0.
//    - byte == HDR0 -> stay in WAIT_HDR1.
//    - any other byte -> IDLE, with no error.
//   PAYLOAD:
//    - shadow[index] = byte; sum = sum + byte, 8-bit wrap.
//    - index == PAYLOAD_LEN-1 -> CHECK; otherwise index + 1.
//   CHECK: uart_data == sum ->
//    - copy shadow to payload_bus in one edge, together with frame_done = 1 for one cycle.
//    - frame_cnt + 1; err_code = 00.
//   CHECK: uart_data != sum -> frame_err = 1 for one cycle, err_code = 01; payload_bus and frame_cnt hold.
//   Both CHECK outcomes return to IDLE. The CHECK byte is never treated as HDR0.
//  Latency: frame_done/frame_err rise on the clock edge after the CHK byte's uart_done is sampled.
//   payload_bus is stable from that edge until the next good frame.
//  Timer: counts sys_clk cycles while state != IDLE; cleared on every uart_done and held at 0 in IDLE.
//   On reaching TIMEOUT_CYC-1: state -> IDLE, frame_err pulse, err_code = 10, shadow discarded.
//   Timeout and uart_done on the same cycle: the byte wins (processed normally, timer cleared).
//  err_code holds its value until the next frame_done (-> 00) or the next frame_err (new code).
//  Partial frames never modify payload_bus. Reset mid-frame behaves as a plain reset; no pulse is emitted.
//  frame_done and frame_err are never high together.
// TESTING
//  1 Send 55 AA 01..0C 4E -> one frame_done pulse; payload_bus[7:0] = 01, [95:88] = 0C;
//    frame_cnt = 1, err_code = 00, busy = 0 afterwards.
//  2 Send 55 AA 01..0C 4F -> one frame_err pulse, err_code = 01;
//    payload_bus and frame_cnt unchanged from test 1.
//  3 Send 00 55 55 AA + 12 x FF + F4 -> resync succeeds;
//    frame_done pulses, payload_bus = all FF (checksum wraps to F4).
//  4 Send 55 AA 01 02, then silence for TIMEOUT_CYC cycles -> frame_err, err_code = 10, busy = 0;
//    a following valid frame is accepted and err_code returns to 00.
//  5 Assert reset after 6 payload bytes -> all outputs 0 asynchronously;
//    after release, a valid frame gives frame_cnt = 1.
//  6 Send 256 back-to-back valid frames -> 256 frame_done pulses, frame_cnt wraps to 0;
//    delivering uart_done exactly on the timeout cycle must not drop the frame.

Source files
------------

// File: rtl/uart_frame_checker.sv
// uart_frame_checker: validates HDR0/HDR1/payload/checksum frames from the UART byte receiver
module uart_frame_checker #(
    parameter int         PAYLOAD_LEN = 12,
    parameter logic [7:0] HDR0        = 8'h55,
    parameter logic [7:0] HDR1        = 8'hAA,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [7:0]               uart_data,
    input  logic                     uart_done,
    output logic [PAYLOAD_LEN*8-1:0] payload_bus,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic [1:0]               err_code,
    output logic [7:0]               frame_cnt,
    output logic                     busy
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, WAIT_HDR1, PAYLOAD, CHECK} state_t;

    state_t                   state, state_nx;
    logic [PAYLOAD_LEN*8-1:0] shadow;
    logic [7:0]               sum, idx;
    logic [TW-1:0]            timer;
    logic                     timeout, good, bad;

    // a byte arriving on the timeout cycle wins, so timeout needs uart_done low
    assign timeout = (state != IDLE) && !uart_done && (timer == TW'(TIMEOUT_CYC - 1));
    assign busy    = state != IDLE;

    // next-state decode; good/bad flag the checksum outcome of the CHK byte
    always_comb begin
        state_nx = state;
        good     = 1'b0;
        bad      = 1'b0;
        if (uart_done) begin
            case (state)
                IDLE:      state_nx = (uart_data == HDR0) ? WAIT_HDR1 : IDLE;
                WAIT_HDR1: state_nx = (uart_data == HDR1) ? PAYLOAD : (uart_data == HDR0) ? WAIT_HDR1 : IDLE;
                PAYLOAD:   state_nx = (idx == 8'(PAYLOAD_LEN - 1)) ? CHECK : PAYLOAD;
                default: begin
                    state_nx = IDLE;
                    good     = uart_data == sum;
                    bad      = uart_data != sum;
                end
            endcase
        end else if (timeout) begin
            state_nx = IDLE;
        end
    end

    // state register
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) state <= IDLE;
        else           state <= state_nx;
    end

    // datapath: shadow capture, running sum, inter-byte timer and result reporting
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            payload_bus <= '0;
            shadow      <= '0;
            sum         <= '0;
            idx         <= '0;
            timer       <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
            frame_cnt   <= '0;
        end else begin
            frame_done <= good;
            frame_err  <= bad || timeout;
            timer      <= (uart_done || timeout || state == IDLE) ? '0 : timer + 1'b1;
            if (uart_done && state == WAIT_HDR1 && uart_data == HDR1) begin
                idx <= '0;
                sum <= '0;
            end
            if (uart_done && state == PAYLOAD) begin
                shadow[idx*8 +: 8] <= uart_data;
                sum                <= sum + uart_data;
                idx                <= idx + 8'd1;
            end
            if (good) begin
                payload_bus <= shadow;
                frame_cnt   <= frame_cnt + 8'd1;
                err_code    <= 2'b00;
            end
            if (bad) err_code <= 2'b01;
            if (timeout) begin
                err_code <= 2'b10;
                shadow   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_checker.sv
// tb_uart_frame_checker: randomized stimulus checked against a byte-queue frame model
module tb_uart_frame_checker;
    localparam int         L  = 12;
    localparam int         T  = 40;
    localparam logic [7:0] H0 = 8'h55;
    localparam logic [7:0] H1 = 8'hAA;
    localparam logic [95:0] P1 = 96'h0c0b0a090807060504030201;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data = '0;
    logic          done = 1'b0;
    logic [L*8-1:0] payload_bus;
    logic          frame_done, frame_err, busy;
    logic [1:0]    err_code;
    logic [7:0]    frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_err    = 0;

    uart_frame_checker #(.PAYLOAD_LEN(L), .HDR0(H0), .HDR1(H1), .TIMEOUT_CYC(T)) dut (
        .sys_clk(clk), .sys_rst_n(rst), .uart_data(data), .uart_done(done),
        .payload_bus(payload_bus), .frame_done(frame_done), .frame_err(frame_err),
        .err_code(err_code), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // model: bytes of the frame gathered so far; empty means hunting for a header
    logic [7:0]  mb[$];
    int          quiet;
    logic [95:0] e_pay;
    logic        e_done, e_err;
    logic [1:0]  e_code;
    logic [7:0]  e_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mb.delete();
            quiet = 0; e_pay = '0; e_done = 0; e_err = 0; e_code = 0; e_cnt = 0;
        end else begin
            e_done = 0;
            e_err  = 0;
            if (done) begin
                quiet = 0;
                if (mb.size() == 0) begin
                    if (data == H0) mb.push_back(data);
                end else if (mb.size() == 1) begin
                    if (data == H1) mb.push_back(data);
                    else if (data != H0) mb.delete();
                end else if (mb.size() < L + 2) begin
                    mb.push_back(data);
                end else begin
                    logic [7:0] s;
                    s = 0;
                    for (int i = 2; i < L + 2; i++) s = s + mb[i];
                    if (s == data) begin
                        e_done = 1; e_cnt = e_cnt + 1; e_code = 0;
                        for (int k = 0; k < L; k++) e_pay[8*k +: 8] = mb[k+2];
                    end else begin
                        e_err = 1; e_code = 1;
                    end
                    mb.delete();
                end
            end else if (mb.size() != 0) begin
                quiet++;
                if (quiet == T) begin
                    quiet = 0; mb.delete(); e_err = 1; e_code = 2;
                end
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("frame_done", 96'(frame_done), 96'(e_done));
            check("frame_err", 96'(frame_err), 96'(e_err));
            check("err_code", 96'(err_code), 96'(e_code));
            check("frame_cnt", 96'(frame_cnt), 96'(e_cnt));
            check("payload_bus", payload_bus, e_pay);
            check("busy", 96'(busy), 96'(mb.size() != 0));
            n_done += int'(frame_done);
            n_err  += int'(frame_err);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        data = b;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        data = $urandom;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [95:0] pay, input bit bad, input int gmin, input int gmax);
        logic [7:0] s;
        s = 0;
        send_byte(H0, $urandom_range(gmin, gmax));
        send_byte(H1, $urandom_range(gmin, gmax));
        for (int k = 0; k < L; k++) begin
            s = s + pay[8*k +: 8];
            send_byte(pay[8*k +: 8], $urandom_range(gmin, gmax));
        end
        send_byte(bad ? s + 8'd1 : s, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int d0, e0;

    initial begin
        repeat (3) @(negedge clk);
        check("reset payload", payload_bus, '0);
        check("reset cnt", 96'(frame_cnt), 0);
        check("reset busy", 96'(busy), 0);
        check("reset pulses", 96'({frame_done, frame_err, err_code}), 0);
        rst = 1'b0;
        @(negedge clk);

        d0 = n_done;
        send_frame(P1, 0, 0, 0);
        @(negedge clk);
        check("t1 pulses", 96'(n_done - d0), 1);
        check("t1 byte0", 96'(payload_bus[7:0]), 96'h01);
        check("t1 byte11", 96'(payload_bus[95:88]), 96'h0c);
        check("t1 cnt", 96'(frame_cnt), 1);
        check("t1 code", 96'(err_code), 0);
        check("t1 busy", 96'(busy), 0);

        e0 = n_err;
        send_frame(P1, 1, 0, 1);
        @(negedge clk);
        check("t2 err pulses", 96'(n_err - e0), 1);
        check("t2 code", 96'(err_code), 1);
        check("t2 payload", payload_bus, P1);
        check("t2 cnt", 96'(frame_cnt), 1);

        send_byte(8'h00, 0);
        send_byte(8'h55, 0);
        send_frame({96{1'b1}}, 0, 0, 0);
        @(negedge clk);
        check("t3 payload", payload_bus, {96{1'b1}});
        check("t3 cnt", 96'(frame_cnt), 2);

        e0 = n_err;
        send_byte(H0, 0); send_byte(H1, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        repeat (T + 2) @(negedge clk);
        check("t4 err pulses", 96'(n_err - e0), 1);
        check("t4 code", 96'(err_code), 2);
        check("t4 busy", 96'(busy), 0);
        send_frame(P1, 0, 0, 2);
        @(negedge clk);
        check("t4 recover code", 96'(err_code), 0);
        check("t4 recover cnt", 96'(frame_cnt), 3);

        send_byte(H0, 0); send_byte(H1, 0);
        for (int k = 0; k < 6; k++) send_byte(8'(k + 9), 0);
        #2 rst = 1'b1;
        #1;
        check("t5 async payload", payload_bus, '0);
        check("t5 async cnt", 96'(frame_cnt), 0);
        check("t5 async busy", 96'(busy), 0);
        check("t5 async code", 96'({frame_done, frame_err, err_code}), 0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(P1, 0, 0, 0);
        @(negedge clk);
        check("t5 cnt", 96'(frame_cnt), 1);

        do_reset();
        d0 = n_done;
        send_frame({$urandom, $urandom, $urandom}, 0, T - 1, T - 1);
        @(negedge clk);
        check("t6 edge-of-timeout frame", 96'(n_done - d0), 1);
        for (int f = 1; f < 256; f++) send_frame({$urandom, $urandom, $urandom}, 0, 0, 1);
        @(negedge clk);
        check("t6 pulses", 96'(n_done - d0), 256);
        check("t6 cnt wrap", 96'(frame_cnt), 0);

        for (int it = 0; it < 200; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)       send_frame({$urandom, $urandom, $urandom}, 0, 0, 3);
            else if (r < 7)  send_frame({$urandom, $urandom, $urandom}, 1, 0, 3);
            else if (r == 7) send_byte(($urandom_range(0, 2) == 0) ? H0 : ($urandom_range(0, 1) == 0) ? H1 : 8'($urandom), $urandom_range(0, 2));
            else if (r == 8) repeat ($urandom_range(T - 2, T + 2)) @(negedge clk);
            else             send_frame({$urandom, $urandom, $urandom}, $urandom_range(0, 1) == 1, 0, T);
        end
        repeat (T + 2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
